// File: rtl/rv16_pkg.sv
// Shared RV32I / RVC encoding constants for the RV16 compress packer.
// Optional feature: RV16C_MEMOP_EN enables C.LW / C.SW compression.
package rv16_pkg;

    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_WORD  = 3'b010;

    localparam logic [1:0] Q0       = 2'b00;
    localparam logic [1:0] Q1       = 2'b01;
    localparam logic [1:0] Q2       = 2'b10;

    localparam logic [2:0] CF3_ADDI = 3'b000;
    localparam logic [2:0] CF3_LI   = 3'b010;
    localparam logic [2:0] CF3_LW   = 3'b010;
    localparam logic [2:0] CF3_SW   = 3'b110;
    localparam logic [3:0] CF4_MV   = 4'b1000;
    localparam logic [3:0] CF4_ADD  = 4'b1001;

    localparam logic [15:0] C_NOP   = 16'h0001;

    // x8..x15 are the only registers reachable by 3-bit RVC fields
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/rv16c_compressor.sv
// Combinational RV32I -> RVC encoder; o_ok flags an exact 16-bit form.
// Optional feature: RV16C_MEMOP_EN adds lw/sw -> C.LW/C.SW.
module rv16c_compressor
    import rv16_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_ok,
    output logic [15:0] o_c_instr
);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm_i;
    logic        imm6_ok;
    logic        is_addi;
    logic        is_add;
    logic        c_li;
    logic        c_addi;
    logic        c_mv;
    logic        c_add;
    logic        c_jr;
    logic        c_lw;
    logic        c_sw;

    assign op    = i_instr[6:0];
    assign rd    = i_instr[11:7];
    assign f3    = i_instr[14:12];
    assign rs1   = i_instr[19:15];
    assign rs2   = i_instr[24:20];
    assign f7    = i_instr[31:25];
    assign imm_i = i_instr[31:20];

    // Immediate fits the signed 6-bit RVC field when bits [11:5] are a sign run
    assign imm6_ok = (f7 == 7'h00) || (f7 == 7'h7f);

    assign is_addi = (op == OP_OPIMM) && (f3 == F3_ADD);
    assign is_add  = (op == OP_OP) && (f3 == F3_ADD) && (f7 == 7'h00);

    assign c_li   = is_addi && (rd != 5'd0) && (rs1 == 5'd0) && imm6_ok;
    assign c_addi = is_addi && (rd != 5'd0) && (rd == rs1)
                    && imm6_ok && (imm_i != 12'd0);
    assign c_mv   = is_add && (rd != 5'd0) && (rs1 == 5'd0)
                    && (rs2 != 5'd0);
    assign c_add  = is_add && (rd != 5'd0) && (rd == rs1)
                    && (rs2 != 5'd0);
    assign c_jr   = (op == OP_JALR) && (f3 == F3_ADD) && (rd == 5'd0)
                    && (imm_i == 12'd0) && (rs1 != 5'd0);

`ifdef RV16C_MEMOP_EN
    logic [11:0] imm_s;
    assign imm_s = {i_instr[31:25], i_instr[11:7]};

    assign c_lw = (op == OP_LOAD) && (f3 == F3_WORD)
                  && is_creg(rd) && is_creg(rs1)
                  && (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
    assign c_sw = (op == OP_STORE) && (f3 == F3_WORD)
                  && is_creg(rs2) && is_creg(rs1)
                  && (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);
`else
    assign c_lw = 1'b0;
    assign c_sw = 1'b0;
`endif

    // Select the RVC encoding; the match terms are mutually exclusive
    always_comb begin
        o_ok      = 1'b1;
        o_c_instr = 16'h0000;
        unique case (1'b1)
            c_li:   o_c_instr = {CF3_LI, i_instr[25], rd, i_instr[24:20], Q1};
            c_addi: o_c_instr = {CF3_ADDI, i_instr[25], rd, i_instr[24:20], Q1};
            c_mv:   o_c_instr = {CF4_MV, rd, rs2, Q2};
            c_add:  o_c_instr = {CF4_ADD, rd, rs2, Q2};
            c_jr:   o_c_instr = {CF4_MV, rs1, 5'd0, Q2};
`ifdef RV16C_MEMOP_EN
            c_lw:   o_c_instr = {CF3_LW, imm_i[5:3], rs1[2:0],
                                 imm_i[2], imm_i[6], rd[2:0], Q0};
            c_sw:   o_c_instr = {CF3_SW, imm_s[5:3], rs1[2:0],
                                 imm_s[2], imm_s[6], rs2[2:0], Q0};
`endif
            default: o_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv16c_compress_packer.sv
// Packs RV32I instructions (compressed where exact) into little-endian words.
// Optional feature: RV16C_MEMOP_EN enables C.LW / C.SW compression.
module rv16c_compress_packer
    import rv16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instruction,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_word,
    output logic             o_flush_done,
    output logic [CNT_W-1:0] o_compressed_count
);

    logic             c_ok;
    logic [15:0]      c_instr;

    logic [15:0]      res_q, res_d;
    logic             res_vld_q, res_vld_d;
    logic [31:0]      word_q, word_d;
    logic             ovld_q, ovld_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             flush_acc;

    rv16c_compressor u_comp (
        .i_instr   (i_instruction),
        .o_ok      (c_ok),
        .o_c_instr (c_instr)
    );

    assign o_ready   = !ovld_q || i_ready;
    assign accept    = i_valid && o_ready;
    assign flush_acc = i_flush && !i_valid && o_ready;

    // Next-state: residue packing, output stage and flush padding
    always_comb begin
        res_d     = res_q;
        res_vld_d = res_vld_q;
        word_d    = word_q;
        ovld_d    = ovld_q && !i_ready;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        if (accept) begin
            if (c_ok) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (res_vld_q) begin
                    word_d    = {c_instr, res_q};
                    ovld_d    = 1'b1;
                    res_vld_d = 1'b0;
                end else begin
                    res_d     = c_instr;
                    res_vld_d = 1'b1;
                end
            end else if (res_vld_q) begin
                word_d = {i_instruction[15:0], res_q};
                res_d  = i_instruction[31:16];
                ovld_d = 1'b1;
            end else begin
                word_d = i_instruction;
                ovld_d = 1'b1;
            end
        end else if (flush_acc) begin
            done_d = 1'b1;
            if (res_vld_q) begin
                word_d    = {C_NOP, res_q};
                ovld_d    = 1'b1;
                res_vld_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            res_q     <= 16'h0000;
            res_vld_q <= 1'b0;
            word_q    <= 32'h0;
            ovld_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            word_q    <= word_d;
            ovld_q    <= ovld_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_valid            = ovld_q;
    assign o_word             = word_q;
    assign o_flush_done       = done_q;
    assign o_compressed_count = cnt_q;

endmodule
